fs_syscall_ctrl: RTL and testbench
==================================

Name: fs_syscall_ctrl

Overview:
- Upstream sequencer for the filesystem block. Accepts one syscall request at a time from the CPU over a valid/ready handshake.
- Presents the syscall fields to the filesystem PIO exports in a glitch-free order: fields first, then syscallId. Holds them for a fixed settle window and captures dataOut.
- Returns a masked result with an error flag over a valid/ready response channel.
- The filesystem PIO interface has no done strobe, so completion is purely cycle-counted.

Parameters:
- SETUP_CYCLES, 4, cycles the fields are driven with syscallId=0 before the id is asserted (min 1).
- SETTLE_CYCLES, 2048, cycles syscallId is held nonzero before dataOut is sampled (min 2).
- GAP_CYCLES, 16, cycles syscallId is held 0 after sampling before the next request may issue (min 1).

Ports:
- CLOCK_50  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_id  in  8  syscall id
- req_path1  in  32  path pointer 1
- req_path2  in  32  path pointer 2
- req_fd  in  32  file descriptor
- req_addr  in  32  file address
- req_bits  in  5  read width; 0 means 32
- req_wdata  in  32  write data
- resp_valid  out  1  response present
- resp_ready  in  1  consumer takes response
- resp_data  out  32  result
- resp_error  out  1  syscall failed or id invalid
- syscallId  out  8  to filesystem
- pathPtr1, pathPtr2, fileDescriptor, fileAddress, writeData  out  32 each  to filesystem
- fileReadBits  out  5  to filesystem
- dataOut  in  32  from filesystem; asynchronous to CLOCK_50

Behaviour:
- Reset (async, reset_n=0): state IDLE; req_ready=1; resp_valid=0; resp_data=0; resp_error=0; syscallId=0; all field outputs 0; counter 0. Taking syscallId to 0 mid-operation aborts the syscall, and no response is produced.
- IDLE: req_ready=1. On req_valid, latch all req_* into the field outputs, then:
  - id valid (1..SYS_MAX): go to SETUP with count=SETUP_CYCLES-1.
  - id invalid (0 or >SYS_MAX): go to RESP with resp_data=32'hFFFF_FFFF and resp_error=1. syscallId never leaves 0.
- SETUP: syscallId=0, fields stable. When count=0, drive syscallId=latched id and go to ACTIVE with count=SETTLE_CYCLES-1.
- ACTIVE: hold id and fields. Pass dataOut through a 2-flop synchronizer. When count=0, capture the synchronizer output, drive syscallId=0 and go to GAP with count=GAP_CYCLES-1. Field outputs stay held.
- Result formatting, computed at capture:
  - SYS_READ: data masked to the low N bits, where N=req_bits and N=0 means all 32. resp_error=0.
  - All other ids: data passed unmasked. resp_error=1 iff the captured value is 32'hFFFF_FFFF.
- GAP: when count=0, go to RESP.
- RESP: resp_valid=1, with resp_data and resp_error stable until resp_ready=1 is sampled. On that edge resp_valid drops and the state returns to IDLE. req_ready rises on the following cycle, so there is no same-cycle accept.
- req_ready=0 in every state except IDLE. req_* is ignored while busy.
- Field outputs keep their last values in IDLE and are overwritten only on accept.
- Worst-case latency from accept to resp_valid: 1 + SETUP_CYCLES + SETTLE_CYCLES + GAP_CYCLES cycles.
- Counter width is clog2 of the maximum parameter. The counter never wraps, because it is reloaded at each state entry.

Decomposition:
- Shared package fs_pkg holds:
  - syscall id constants: SYS_NONE=0, SYS_OPEN=1, SYS_CLOSE=2, SYS_READ=3, SYS_WRITE=4, SYS_DELETE=5, SYS_RENAME=6, SYS_MAX=6
  - state enum
  - FS_ERR=32'hFFFF_FFFF
- One sub-module, fs_sync2: a 32-bit two-flop synchronizer for dataOut, with async reset to 0.

Test Plan (SETUP=4, SETTLE=8, GAP=2):
- Reset: assert reset_n=0 during ACTIVE of an OPEN -> syscallId=0 immediately; req_ready=1, resp_valid=0 after release; no response is ever produced.
- OPEN: id=1, path1=0x100, fs returns dataOut=5 -> syscallId=0 for 4 cycles, then 1 for 8 cycles, then 0 again. resp_data=5, resp_error=0, resp_valid 15 cycles after accept.
- READ mask: id=3, bits=8, dataOut=0xDEADBEEF -> resp_data=0x000000EF, resp_error=0. Repeat with bits=0 -> resp_data=0xDEADBEEF.
- Error: id=1 with dataOut=0xFFFFFFFF -> resp_error=1. id=3 with dataOut=0xFFFFFFFF and bits=0 -> resp_error=0.
- Invalid id: id=9 -> syscallId stays 0 throughout; resp_data=0xFFFFFFFF, resp_error=1 within 2 cycles.
- Backpressure: hold resp_ready=0 for 20 cycles with a second req_valid pending -> resp stays stable, req_ready=0, and the second request is accepted only on the cycle after resp_ready=1.

Source files
------------

// File: rtl/fs_pkg.sv
// Shared constants and types for the filesystem syscall sequencer.
// Syscall ids, FSM states and the read-width mask helper.
package fs_pkg;

    localparam logic [7:0] SYS_NONE   = 8'd0;
    localparam logic [7:0] SYS_OPEN   = 8'd1;
    localparam logic [7:0] SYS_CLOSE  = 8'd2;
    localparam logic [7:0] SYS_READ   = 8'd3;
    localparam logic [7:0] SYS_WRITE  = 8'd4;
    localparam logic [7:0] SYS_DELETE = 8'd5;
    localparam logic [7:0] SYS_RENAME = 8'd6;
    localparam logic [7:0] SYS_MAX    = 8'd6;

    localparam logic [31:0] FS_ERR = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_ACTIVE = 3'd2,
        ST_GAP    = 3'd3,
        ST_RESP   = 3'd4
    } fs_state_e;

    // A width of 0 selects the full 32-bit word.
    function automatic logic [31:0] fs_read_mask(input logic [4:0] bits);
        return (bits == 5'd0) ? 32'hFFFF_FFFF : ((32'd1 << bits) - 32'd1);
    endfunction

endpackage

// File: rtl/fs_syscall_ctrl_sync.sv
// Two-flop synchronizer bringing the filesystem dataOut bus into CLOCK_50.
// Sampled only after a long settle window, so per-bit skew is harmless.
module fs_sync2 #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/fs_syscall_ctrl.sv
// Cycle-counted sequencer driving the filesystem PIO exports:
// fields first, then syscallId, settle, capture, gap, respond.
module fs_syscall_ctrl
    import fs_pkg::*;
#(
    parameter int unsigned SETUP_CYCLES  = 4,
    parameter int unsigned SETTLE_CYCLES = 2048,
    parameter int unsigned GAP_CYCLES    = 16
) (
    input  logic        CLOCK_50,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_id,
    input  logic [31:0] req_path1,
    input  logic [31:0] req_path2,
    input  logic [31:0] req_fd,
    input  logic [31:0] req_addr,
    input  logic [4:0]  req_bits,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        resp_error,
    output logic [7:0]  syscallId,
    output logic [31:0] pathPtr1,
    output logic [31:0] pathPtr2,
    output logic [31:0] fileDescriptor,
    output logic [31:0] fileAddress,
    output logic [31:0] writeData,
    output logic [4:0]  fileReadBits,
    input  logic [31:0] dataOut
);

    localparam int unsigned MAX_A = (SETUP_CYCLES > SETTLE_CYCLES) ? SETUP_CYCLES : SETTLE_CYCLES;
    localparam int unsigned MAX_P = (MAX_A > GAP_CYCLES) ? MAX_A : GAP_CYCLES;
    localparam int unsigned CNT_W = (MAX_P > 1) ? $clog2(MAX_P) : 1;

    localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LD    = CNT_W'(GAP_CYCLES - 1);

    fs_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       id_q, id_d;
    logic [7:0]       sid_q, sid_d;
    logic [31:0]      path1_q, path1_d;
    logic [31:0]      path2_q, path2_d;
    logic [31:0]      fd_q, fd_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [4:0]       bits_q, bits_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             rerr_q, rerr_d;
    logic [31:0]      sync_data;
    logic             cnt_zero;
    logic             id_ok;

    fs_sync2 #(.W(32)) u_sync (
        .clk   (CLOCK_50),
        .rst_n (reset_n),
        .d     (dataOut),
        .q     (sync_data)
    );

    assign cnt_zero = (cnt_q == '0);
    assign id_ok    = (req_id != SYS_NONE) && (req_id <= SYS_MAX);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        id_d    = id_q;
        sid_d   = sid_q;
        path1_d = path1_q;
        path2_d = path2_q;
        fd_d    = fd_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        bits_d  = bits_q;
        rdata_d = rdata_q;
        rerr_d  = rerr_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    id_d    = req_id;
                    path1_d = req_path1;
                    path2_d = req_path2;
                    fd_d    = req_fd;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    bits_d  = req_bits;
                    if (id_ok) begin
                        state_d = ST_SETUP;
                        cnt_d   = SETUP_LD;
                    end else begin
                        state_d = ST_RESP;
                        rdata_d = FS_ERR;
                        rerr_d  = 1'b1;
                    end
                end
            end
            ST_SETUP: begin
                if (cnt_zero) begin
                    sid_d   = id_q;
                    state_d = ST_ACTIVE;
                    cnt_d   = SETTLE_LD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_ACTIVE: begin
                if (cnt_zero) begin
                    if (id_q == SYS_READ) begin
                        rdata_d = sync_data & fs_read_mask(bits_q);
                        rerr_d  = 1'b0;
                    end else begin
                        rdata_d = sync_data;
                        rerr_d  = (sync_data == FS_ERR);
                    end
                    sid_d   = SYS_NONE;
                    state_d = ST_GAP;
                    cnt_d   = GAP_LD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (cnt_zero) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            id_q    <= '0;
            sid_q   <= '0;
            path1_q <= '0;
            path2_q <= '0;
            fd_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            bits_q  <= '0;
            rdata_q <= '0;
            rerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            id_q    <= id_d;
            sid_q   <= sid_d;
            path1_q <= path1_d;
            path2_q <= path2_d;
            fd_q    <= fd_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            bits_q  <= bits_d;
            rdata_q <= rdata_d;
            rerr_q  <= rerr_d;
        end
    end

    assign req_ready      = (state_q == ST_IDLE);
    assign resp_valid     = (state_q == ST_RESP);
    assign resp_data      = rdata_q;
    assign resp_error     = rerr_q;
    assign syscallId      = sid_q;
    assign pathPtr1       = path1_q;
    assign pathPtr2       = path2_q;
    assign fileDescriptor = fd_q;
    assign fileAddress    = addr_q;
    assign writeData      = wdata_q;
    assign fileReadBits   = bits_q;

endmodule

// File: tb/tb_fs_syscall_ctrl.sv
// Directed plus randomized bench for fs_syscall_ctrl with short windows.
// Expected results come from a syscall-level model of the result rules.
module tb_fs_syscall_ctrl;

    localparam int SETUP  = 4;
    localparam int SETTLE = 8;
    localparam int GAP    = 2;

    logic        CLOCK_50 = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_id;
    logic [31:0] req_path1, req_path2, req_fd, req_addr, req_wdata;
    logic [4:0]  req_bits;
    logic        resp_valid, resp_ready;
    logic [31:0] resp_data;
    logic        resp_error;
    logic [7:0]  syscallId;
    logic [31:0] pathPtr1, pathPtr2, fileDescriptor, fileAddress, writeData;
    logic [4:0]  fileReadBits;
    logic [31:0] dataOut;

    int errors = 0;
    int checks = 0;

    fs_syscall_ctrl #(
        .SETUP_CYCLES  (SETUP),
        .SETTLE_CYCLES (SETTLE),
        .GAP_CYCLES    (GAP)
    ) dut (
        .CLOCK_50       (CLOCK_50),
        .reset_n        (reset_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_id         (req_id),
        .req_path1      (req_path1),
        .req_path2      (req_path2),
        .req_fd         (req_fd),
        .req_addr       (req_addr),
        .req_bits       (req_bits),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_data      (resp_data),
        .resp_error     (resp_error),
        .syscallId      (syscallId),
        .pathPtr1       (pathPtr1),
        .pathPtr2       (pathPtr2),
        .fileDescriptor (fileDescriptor),
        .fileAddress    (fileAddress),
        .writeData      (writeData),
        .fileReadBits   (fileReadBits),
        .dataOut        (dataOut)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Result rules: {error, data}
    function automatic logic [32:0] model(input logic [7:0] id, input logic [4:0] bits,
                                          input logic [31:0] d);
        longint unsigned v;
        if (id == 8'd0 || id > 8'd6) return {1'b1, 32'hFFFF_FFFF};
        if (id == 8'd3) begin
            v = (bits == 5'd0) ? longint'(d) : longint'(d) % (64'd1 << bits);
            return {1'b0, v[31:0]};
        end
        return {(d == 32'hFFFF_FFFF), d};
    endfunction

    // Called on a negedge while idle; returns on a negedge, idle again.
    task automatic run_op(input logic [7:0] id, input logic [4:0] bits,
                          input logic [31:0] dout, input int hold);
        logic [31:0] p1, p2, fd, ad, wd;
        logic [32:0] m;
        logic        valid;
        int          k;
        int          exp_edges;
        p1 = $urandom; p2 = $urandom; fd = $urandom; ad = $urandom; wd = $urandom;
        valid = (id >= 8'd1 && id <= 8'd6);
        // counting the accept edge as edge 1
        exp_edges = valid ? 1 + SETUP + SETTLE + GAP : 1;
        m = model(id, bits, dout);
        dataOut   = dout;
        req_id    = id;
        req_bits  = bits;
        req_path1 = p1; req_path2 = p2; req_fd = fd; req_addr = ad; req_wdata = wd;
        req_valid = 1'b1;
        check("req_ready_idle", 64'(req_ready), 64'd1);
        @(posedge CLOCK_50);
        #1 req_valid = 1'b0;
        @(negedge CLOCK_50);
        check("fields_path", {pathPtr1, pathPtr2}, {p1, p2});
        check("fields_fd_addr", {fileDescriptor, fileAddress}, {fd, ad});
        check("fields_wd_bits", {writeData, 27'd0, fileReadBits}, {wd, 27'd0, bits});
        k = 0;
        while (!resp_valid && k < 200) begin
            check("syscallId_seq", 64'(syscallId),
                  (valid && k >= SETUP && k < SETUP + SETTLE) ? 64'(id) : 64'd0);
            k++;
            @(negedge CLOCK_50);
        end
        check("latency", 64'(k + 1), 64'(exp_edges));
        check("resp", {31'd0, resp_error, resp_data}, {31'd0, m});
        check("syscallId_resp", 64'(syscallId), 64'd0);
        if (hold > 0) begin
            req_id    = 8'd4;
            req_fd    = ~fd;
            req_valid = 1'b1;
        end
        for (int i = 0; i < hold; i++) begin
            check("bp_req_ready", 64'(req_ready), 64'd0);
            check("bp_resp", {30'd0, resp_valid, resp_error, resp_data}, {30'd0, 1'b1, m});
            @(negedge CLOCK_50);
        end
        resp_ready = 1'b1;
        @(posedge CLOCK_50);
        #1 resp_ready = 1'b0;
        @(negedge CLOCK_50);
        check("released", {62'd0, req_ready, resp_valid}, {62'd0, 1'b1, 1'b0});
        check("fd_held", 64'(fileDescriptor), 64'(fd));
        req_valid = 1'b0;
    endtask

    initial begin
        logic [7:0]  rid;
        logic [31:0] rd;
        logic        seen;
        reset_n = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
        req_id = '0; req_path1 = '0; req_path2 = '0; req_fd = '0;
        req_addr = '0; req_bits = '0; req_wdata = '0; dataOut = '0;
        repeat (3) @(negedge CLOCK_50);
        check("rst_ctrl", {61'd0, req_ready, resp_valid, resp_error}, {61'd0, 3'b100});
        check("rst_data_id", {24'd0, syscallId, resp_data}, 64'd0);
        check("rst_fields", {pathPtr1, fileDescriptor}, 64'd0);
        reset_n = 1'b1;
        @(negedge CLOCK_50);

        run_op(8'd1, 5'd0, 32'd5, 0);
        run_op(8'd3, 5'd8, 32'hDEAD_BEEF, 0);
        run_op(8'd3, 5'd0, 32'hDEAD_BEEF, 0);
        run_op(8'd1, 5'd0, 32'hFFFF_FFFF, 0);
        run_op(8'd3, 5'd0, 32'hFFFF_FFFF, 0);
        run_op(8'd9, 5'd0, 32'h1234, 0);
        run_op(8'd0, 5'd3, 32'h1234, 0);
        run_op(8'd2, 5'd0, 32'd7, 20);
        run_op(8'd6, 5'd31, 32'h8000_0001, 1);

        for (int n = 0; n < 10; n++) begin
            rid = 8'($urandom_range(0, 8));
            rd  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
            run_op(rid, 5'($urandom), rd, $urandom_range(0, 3));
        end

        // abort an OPEN with reset while syscallId is asserted
        dataOut = 32'd5; req_id = 8'd1; req_path1 = 32'h100; req_bits = '0;
        req_valid = 1'b1;
        @(posedge CLOCK_50);
        #1 req_valid = 1'b0;
        repeat (7) @(negedge CLOCK_50);
        check("abort_id_before", 64'(syscallId), 64'd1);
        #1 reset_n = 1'b0;
        #1;
        check("abort_id_async", 64'(syscallId), 64'd0);
        check("abort_ctrl", {62'd0, req_ready, resp_valid}, {62'd0, 2'b10});
        check("abort_fields", 64'(pathPtr1), 64'd0);
        @(negedge CLOCK_50);
        reset_n = 1'b1;
        seen = 1'b0;
        repeat (30) begin
            @(negedge CLOCK_50);
            if (resp_valid || syscallId != 8'd0) seen = 1'b1;
        end
        check("abort_no_resp", 64'(seen), 64'd0);
        check("abort_idle", 64'(req_ready), 64'd1);

        run_op(8'd5, 5'd0, 32'h0000_00A5, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
